// File: rtl/uart_rx_led_pkg.sv
// Shared receiver definitions: FSM state encoding and bit-period derivation.
package uart_rx_led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Integer divide; the result must be at least 8 for the half-bit sample to be meaningful.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_led_core.sv
// 8N1 receive core: rx synchroniser, framing FSM, LSB-first shifter and a one-cycle byte strobe.
module uart_rx_core
    import uart_rx_led_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_strobe,
    output logic       frame_err
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_BIT = TIMER_W'(CLKS_PER_BIT / 2);
    localparam logic [TIMER_W-1:0] LAST_CLK = TIMER_W'(CLKS_PER_BIT - 1);

    logic               rx_meta;
    logic               rx_s;
    rx_state_t          state;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;

    // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // NOTE: non-blocking assignments everywhere here, so every decision uses pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (!rx_s)
                        state <= ST_START;
                end
                ST_START: begin
                    if (timer == HALF_BIT) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (timer == LAST_CLK) begin
                        timer          <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7)
                            state <= ST_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (timer == LAST_CLK) begin
                        timer <= '0;
                        // Returning to IDLE at mid-stop re-arms in time for a back-to-back start bit.
                        if (rx_s) begin
                            byte_strobe <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_BREAK: begin
                    timer <= '0;
                    if (rx_s)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // shreg is untouched until the next frame's first data sample, so it is safe to expose directly.
    assign byte_data = shreg;

endmodule

// File: rtl/uart_rx_led.sv
// UART receiver top: valid/ready holding register, sticky overrun and LED echo of the low nibble.
module uart_rx_led
    import uart_rx_led_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic [3:0] led
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

    logic [7:0] rx_byte;
    logic       rx_strobe;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (rx_byte),
        .byte_strobe(rx_strobe),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data       <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            led        <= '0;
        end else if (rx_strobe) begin
            // A byte being consumed this cycle frees the register for the new one.
            if (!data_valid || data_ready) begin
                data       <= rx_byte;
                led        <= rx_byte[3:0];
                data_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

endmodule
